autosa_glb_csb_tgt: RTL and testbench
=====================================

AUTOSA_GLB_CSB_TGT -- requirements
Module: autosa_glb_csb_tgt

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 32-bit registers, range 1..256.
REQ-002 SHALL have parameter BASE_ADDR, default 22'h0: word address of register 0.
REQ-003 SHALL have parameter RESP_DEPTH, default 4: response queue entries, power of two, range 2..16.
REQ-004 SHALL have port autosa_core_clk  in  1: the only clock.
REQ-005 SHALL have port autosa_core_rstn  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port csb2gec_req_pvld  in  1: request valid.
REQ-007 SHALL have port csb2gec_req_prdy  out  1: request ready.
REQ-008 SHALL have port csb2gec_req_pd  in  63: request fields, LSB first: addr[21:0], wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61].
REQ-009 SHALL have port gec2csb_resp_valid  out  1: response valid.
REQ-010 SHALL have port gec2csb_resp_prdy  in  1: response ready; this is new backpressure.
REQ-011 SHALL have port gec2csb_resp_pd  out  34: response fields: rdat[31:0], error[32], id[33] (0 = read, 1 = write).
REQ-012 SHALL have port reg_q  out  NUM_REGS*32: flat register contents, register i at bits [32i+31:32i].

Function
REQ-013 SHALL accept a request only on a cycle where pvld and prdy are both 1.
REQ-014 SHALL drive csb2gec_req_prdy = ~full, where full is taken from the registered queue count; a same-cycle pop SHALL NOT raise prdy.
REQ-015 SHALL compute idx = addr - BASE_ADDR and treat it as a hit iff 0 <= idx < NUM_REGS, with the compare done at 22-bit width and no wrap.
REQ-016 SHALL update, for an accepted write hit, reg[idx] bytes b where wrbe[b] = 1, in the accept cycle (visible the next cycle); wrbe = 0 leaves the register unchanged.
REQ-017 SHALL ignore the write data of an accepted write miss and leave all registers unchanged.
REQ-018 SHALL push, for an accepted read, {id=0, error=miss, rdat = hit ? reg[idx] : 0}, where rdat is the pre-write value.
REQ-019 SHALL push, for an accepted nposted write, {id=1, error=miss, rdat=0}.
REQ-020 SHALL NOT generate a response for a posted write (nposted = 0).
REQ-021 SHALL make a pushed response visible on gec2csb_resp_valid/pd the next cycle at the earliest (1-cycle latency into an empty queue).
REQ-022 SHALL deliver responses in FIFO order.
REQ-023 SHALL pop the head when valid & resp_prdy; valid and pd SHALL hold stable while resp_prdy = 0.
REQ-024 SHALL allow a push and a pop in the same cycle, leaving the count unchanged.
REQ-025 SHALL ignore the level field.

Reset
REQ-026 SHALL, when autosa_core_rstn = 0 at a clock edge, clear all registers to 0, empty the queue, and set gec2csb_resp_valid = 0 and gec2csb_resp_pd = 0.
REQ-027 SHALL hold csb2gec_req_prdy = 1 after reset.
REQ-028 SHALL discard queued responses when reset occurs mid-operation; none are replayed.

Configuration
REQ-029 SHALL, with macro AUTOSA_CSB_PRIV_CHECK_EN defined, treat a write with srcpriv = 0 as not updating registers and set error = 1 in its response if nposted; reads are unaffected.
REQ-030 SHALL, without AUTOSA_CSB_PRIV_CHECK_EN, ignore srcpriv entirely.

Structure
REQ-031 SHALL take request/response field offsets, widths, packet widths and the read/write ID constants from shared package autosa_csb_pkg.
REQ-032 SHALL implement the response queue as sub-module autosa_glb_csb_resp_fifo (parameters WIDTH, DEPTH; push/pop/full/empty; synchronous active-low reset).

Verification
REQ-033 SHALL verify: write 0xDEADBEEF to BASE_ADDR+3 with wrbe = 4'b0101, nposted -> one response id=1, error=0; then a read of BASE_ADDR+3 -> rdat 0x00AD00EF.
REQ-034 SHALL verify: read of BASE_ADDR+NUM_REGS -> rdat 0, error=1, id=0; no register changes.
REQ-035 SHALL verify: resp_prdy held at 0, RESP_DEPTH+1 back-to-back reads -> prdy drops after RESP_DEPTH accepts; on release, responses arrive in order.
REQ-036 SHALL verify: posted write to BASE_ADDR -> reg_q updated next cycle, resp_valid stays 0.
REQ-037 SHALL verify: queue full with push and pop attempted together -> no accept (prdy = 0), pop proceeds; next cycle prdy = 1.
REQ-038 SHALL verify: reset asserted with 2 responses queued -> resp_valid = 0 and reg_q = 0 the next cycle; with AUTOSA_CSB_PRIV_CHECK_EN, an nposted write with srcpriv = 0 -> error=1 and the register unchanged.

Source files
------------

// File: rtl/autosa_csb_pkg.sv
// Shared CSB packet layout: request/response field offsets, widths and response IDs,
// plus helpers for byte-enable merge and response packing.
package autosa_csb_pkg;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 32;
    localparam int WRBE_W  = 4;
    localparam int LEVEL_W = 2;

    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;
    localparam int REQ_SRCPRIV_BIT = 56;
    localparam int REQ_WRBE_LSB    = 57;
    localparam int REQ_LEVEL_LSB   = 61;
    localparam int REQ_PD_W        = 63;

    localparam int RESP_RDAT_LSB  = 0;
    localparam int RESP_ERROR_BIT = 32;
    localparam int RESP_ID_BIT    = 33;
    localparam int RESP_PD_W      = 34;

    localparam logic RESP_ID_READ  = 1'b0;
    localparam logic RESP_ID_WRITE = 1'b1;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [WRBE_W-1:0] be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < WRBE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic [RESP_PD_W-1:0] make_resp(
        input logic              id,
        input logic              error,
        input logic [DATA_W-1:0] rdat
    );
        logic [RESP_PD_W-1:0] resp;
        resp                             = '0;
        resp[RESP_RDAT_LSB +: DATA_W]    = rdat;
        resp[RESP_ERROR_BIT]             = error;
        resp[RESP_ID_BIT]                = id;
        return resp;
    endfunction

endpackage

// File: rtl/autosa_glb_csb_resp_fifo.sv
// Small response FIFO with count-based full/empty; head word is presented
// combinationally and forced to zero while empty so it is clean out of reset.
module autosa_glb_csb_resp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/autosa_glb_csb_tgt.sv
// CSB target exposing NUM_REGS 32-bit registers with a queued response path.
// Optional source-privilege write filtering is enabled by AUTOSA_CSB_PRIV_CHECK_EN.
module autosa_glb_csb_tgt
    import autosa_csb_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter logic [21:0] BASE_ADDR  = 22'h0,
    parameter int          RESP_DEPTH = 4
) (
    input  logic                       autosa_core_clk,
    input  logic                       autosa_core_rstn,
    input  logic                       csb2gec_req_pvld,
    output logic                       csb2gec_req_prdy,
    input  logic [REQ_PD_W-1:0]        csb2gec_req_pd,
    output logic                       gec2csb_resp_valid,
    input  logic                       gec2csb_resp_prdy,
    output logic [RESP_PD_W-1:0]       gec2csb_resp_pd,
    output logic [NUM_REGS*32-1:0]     reg_q
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdat;
    logic               write;
    logic               nposted;
    logic [WRBE_W-1:0]  wrbe;
    logic [LEVEL_W-1:0] unused_level;

    assign addr         = csb2gec_req_pd[REQ_ADDR_LSB +: ADDR_W];
    assign wdat         = csb2gec_req_pd[REQ_WDAT_LSB +: DATA_W];
    assign write        = csb2gec_req_pd[REQ_WRITE_BIT];
    assign nposted      = csb2gec_req_pd[REQ_NPOSTED_BIT];
    assign wrbe         = csb2gec_req_pd[REQ_WRBE_LSB +: WRBE_W];
    assign unused_level = csb2gec_req_pd[REQ_LEVEL_LSB +: LEVEL_W];

    // Extend to 23 bits so addresses below BASE_ADDR cannot wrap into the window.
    logic [ADDR_W:0] addr_ext;
    logic [ADDR_W:0] base_ext;
    logic [ADDR_W:0] diff;
    logic            hit;
    logic [IDX_W-1:0] idx;

    assign addr_ext = {1'b0, addr};
    assign base_ext = {1'b0, BASE_ADDR};
    assign diff     = addr_ext - base_ext;
    assign hit      = (addr_ext >= base_ext) && (diff < (ADDR_W+1)'(NUM_REGS));
    assign idx      = diff[IDX_W-1:0];

    logic priv_ok;
`ifdef AUTOSA_CSB_PRIV_CHECK_EN
    assign priv_ok = csb2gec_req_pd[REQ_SRCPRIV_BIT] | ~write;
`else
    logic unused_srcpriv;
    assign unused_srcpriv = csb2gec_req_pd[REQ_SRCPRIV_BIT];
    assign priv_ok        = 1'b1;
`endif

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic wr_en;
    logic resp_push;
    logic resp_pop;
    logic [DATA_W-1:0]    rd_data;
    logic [RESP_PD_W-1:0] resp_din;
    logic [DATA_W-1:0]    regs [NUM_REGS];

    assign csb2gec_req_prdy   = ~fifo_full;
    assign accept             = csb2gec_req_pvld & csb2gec_req_prdy;
    assign wr_en              = accept & write & hit & priv_ok;
    assign resp_push          = accept & (~write | nposted);
    assign gec2csb_resp_valid = ~fifo_empty;
    assign resp_pop           = gec2csb_resp_valid & gec2csb_resp_prdy;

    // Reads return the pre-write register value; only one request per cycle anyway.
    assign rd_data  = hit ? regs[idx] : '0;
    assign resp_din = make_resp(write ? RESP_ID_WRITE : RESP_ID_READ,
                                ~hit | ~priv_ok,
                                write ? '0 : rd_data);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge autosa_core_clk) begin
                if (!autosa_core_rstn) begin
                    word_reg <= '0;
                end else if (wr_en && (idx == IDX_W'(gi))) begin
                    word_reg <= byte_merge(word_reg, wdat, wrbe);
                end
            end

            assign regs[gi]             = word_reg;
            assign reg_q[gi*32 +: 32]   = word_reg;
        end
    endgenerate

    autosa_glb_csb_resp_fifo #(
        .WIDTH (RESP_PD_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (autosa_core_clk),
        .rstn  (autosa_core_rstn),
        .push  (resp_push),
        .din   (resp_din),
        .pop   (resp_pop),
        .dout  (gec2csb_resp_pd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_autosa_glb_csb_tgt.sv
// Directed + randomized bench for autosa_glb_csb_tgt against a queue/array reference model.
module tb_autosa_glb_csb_tgt;

    localparam int          NUM_REGS   = 16;
    localparam logic [21:0] BASE       = 22'h120;
    localparam int          DEPTH      = 4;

    logic                   clk;
    logic                   rstn;
    logic                   pvld;
    logic                   prdy;
    logic [62:0]            pd;
    logic                   rvalid;
    logic                   rprdy;
    logic [33:0]            rpd;
    logic [NUM_REGS*32-1:0] reg_q;

    autosa_glb_csb_tgt #(
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .autosa_core_clk    (clk),
        .autosa_core_rstn   (rstn),
        .csb2gec_req_pvld   (pvld),
        .csb2gec_req_prdy   (prdy),
        .csb2gec_req_pd     (pd),
        .gec2csb_resp_valid (rvalid),
        .gec2csb_resp_prdy  (rprdy),
        .gec2csb_resp_pd    (rpd),
        .reg_q              (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_regs [NUM_REGS];
    logic [33:0] m_q [$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [21:0] addr_of(input int off);
        return 22'(int'(BASE) + off);
    endfunction

    function automatic logic [62:0] mk_req(input logic [21:0] a, input logic [31:0] d,
                                           input logic wr, input logic np, input logic sp,
                                           input logic [3:0] be, input logic [1:0] lvl);
        return {lvl, be, sp, np, wr, d, a};
    endfunction

    function automatic logic [NUM_REGS*32-1:0] model_flat();
        logic [NUM_REGS*32-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_q.delete();
    endtask

    // One clock: drive, compare pre-edge outputs to the model, advance model and clock.
    task automatic step(input logic v, input logic [62:0] req, input logic rp, input logic rst_n);
        logic [21:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        wr, np, sp, acc, pop, hit, blocked;
        int          off;
        logic [33:0] head;
        logic [NUM_REGS*32-1:0] expf;

        pvld = v; pd = req; rprdy = rp; rstn = rst_n;
        #1;
        head = (m_q.size() > 0) ? m_q[0] : 34'h0;
        check("prdy", 64'(prdy), 64'(m_q.size() < DEPTH));
        check("resp_valid", 64'(rvalid), 64'(m_q.size() > 0));
        check("resp_pd", 64'(rpd), 64'(head));
        expf = model_flat();
        checks++;
        assert (reg_q === expf) passes++;
        else $error("FAIL reg_q observed=%h expected=%h", reg_q, expf);

        if (!rst_n) begin
            model_clear();
        end else begin
            a = req[21:0]; d = req[53:22]; wr = req[54]; np = req[55]; sp = req[56]; be = req[60:57];
            acc = v && (m_q.size() < DEPTH);
            pop = (m_q.size() > 0) && rp;
            off = int'(a) - int'(BASE);
            hit = (off >= 0) && (off < NUM_REGS);
`ifdef AUTOSA_CSB_PRIV_CHECK_EN
            blocked = wr && !sp;
`else
            blocked = 1'b0;
`endif
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                if (!wr) begin
                    m_q.push_back({1'b0, !hit, hit ? m_regs[off] : 32'h0});
                end else begin
                    if (hit && !blocked)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) m_regs[off][8*b +: 8] = d[8*b +: 8];
                    if (np) m_q.push_back({1'b1, !hit || blocked, 32'h0});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [62:0] idle;
        idle = '0;
        pvld = 1'b0; pd = '0; rprdy = 1'b0; rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        check("rst_prdy", 64'(prdy), 64'(1'b1));
        check("rst_valid", 64'(rvalid), 64'(1'b0));
        check("rst_pd", 64'(rpd), 64'(34'h0));
        check("rst_reg0", 64'(reg_q[31:0]), 64'(32'h0));

        // Byte-enabled nposted write then read-back
        step(1'b1, mk_req(addr_of(3), 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 4'b0101, 2'd2), 1'b1, 1'b1);
        check("wr_resp", 64'(rpd), 64'(34'h2_0000_0000));
        check("wr_resp_valid", 64'(rvalid), 64'(1'b1));
        step(1'b1, mk_req(addr_of(3), 32'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1), 1'b1, 1'b1);
        check("rd_resp", 64'(rpd), 64'(34'h0_00AD_00EF));
        check("reg3", 64'(reg_q[3*32 +: 32]), 64'(32'h00AD00EF));
        step(1'b0, idle, 1'b1, 1'b1);

        // Misses: one past the window and one below the base
        step(1'b1, mk_req(addr_of(NUM_REGS), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b1, 1'b1);
        check("miss_hi", 64'(rpd), 64'(34'h1_0000_0000));
        step(1'b1, mk_req(addr_of(-1), 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0), 1'b1, 1'b1);
        check("miss_lo_wr", 64'(rpd), 64'(34'h3_0000_0000));
        step(1'b0, idle, 1'b1, 1'b1);

        // Posted write: register updates, no response
        step(1'b1, mk_req(addr_of(0), 32'h1234_5678, 1'b1, 1'b0, 1'b1, 4'hF, 2'd3), 1'b1, 1'b1);
        check("posted_reg0", 64'(reg_q[31:0]), 64'(32'h1234_5678));
        check("posted_valid", 64'(rvalid), 64'(1'b0));

        // Fill the queue under backpressure, then pop while a request is refused
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk_req(addr_of(i), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b0, 1'b1);
        check("full_prdy", 64'(prdy), 64'(1'b0));
        step(1'b1, mk_req(addr_of(DEPTH), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b0, 1'b1);
        check("hold_pd", 64'(rpd), 64'({2'b00, 32'h1234_5678}));
        step(1'b1, mk_req(addr_of(DEPTH), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b1, 1'b1);
        check("prdy_after_pop", 64'(prdy), 64'(1'b1));
        step(1'b1, mk_req(addr_of(DEPTH), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b1, 1'b1);
        repeat (DEPTH + 1) step(1'b0, idle, 1'b1, 1'b1);
        check("drained", 64'(rvalid), 64'(1'b0));

        // Random traffic around the register window
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7),
                 mk_req(addr_of(int'($urandom_range(0, NUM_REGS + 5)) - 3), $urandom,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3))),
                 ($urandom_range(0, 9) < 6), 1'b1);
        end
        repeat (DEPTH + 1) step(1'b0, idle, 1'b1, 1'b1);

        // Reset with responses pending
        step(1'b1, mk_req(addr_of(5), 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 4'hF, 2'd0), 1'b0, 1'b1);
        step(1'b1, mk_req(addr_of(5), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b0, 1'b1);
        step(1'b1, mk_req(addr_of(6), 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0), 1'b0, 1'b1);
        check("pre_rst_valid", 64'(rvalid), 64'(1'b1));
        step(1'b0, idle, 1'b0, 1'b0);
        check("mid_rst_valid", 64'(rvalid), 64'(1'b0));
        check("mid_rst_reg5", 64'(reg_q[5*32 +: 32]), 64'(32'h0));
        check("mid_rst_pd", 64'(rpd), 64'(34'h0));
        step(1'b0, idle, 1'b1, 1'b1);
        check("post_rst_prdy", 64'(prdy), 64'(1'b1));

`ifdef AUTOSA_CSB_PRIV_CHECK_EN
        step(1'b1, mk_req(addr_of(2), 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 4'hF, 2'd0), 1'b1, 1'b1);
        check("priv_resp", 64'(rpd), 64'(34'h3_0000_0000));
        check("priv_reg2", 64'(reg_q[2*32 +: 32]), 64'(32'h0));
`else
        step(1'b1, mk_req(addr_of(2), 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 4'hF, 2'd0), 1'b1, 1'b1);
        check("nopriv_resp", 64'(rpd), 64'(34'h2_0000_0000));
        check("nopriv_reg2", 64'(reg_q[2*32 +: 32]), 64'(32'hCAFE_F00D));
`endif
        step(1'b0, idle, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
